axis_mixer_fs4: RTL and testbench
=================================

// Module: axis_mixer_fs4
// PURPOSE
//  Parametrised AXI-Stream fs/4 / fs/2 mixer: N parallel complex lanes (I,Q) in, N real lanes out.
//  Successor to the fixed 16-lane mixer: any lane count, any sample width, a running phase across
//  beats, a fourth mode, backpressure, and mode changes taken only at packet boundaries.
//  Sits between the interpolator output and the DAC-side real datapath.
// PARAMETERS
//  N   16  lanes per beat (1..64); lane k = sample n*N+k.
//  B   16  sample width, two's complement, for I, Q and the output.
// PORTS
//  clk             in   1      single clock.
//  rst             in   1      synchronous, active-high reset.
//  s_axis_tdata    in   N*2*B  lane k: I=[2Bk +: B], Q=[2Bk+B +: B].
//  s_axis_tvalid   in   1      input beat valid.
//  s_axis_tready   out  1      input beat accepted when valid&ready.
//  s_axis_tlast    in   1      last beat of packet; applies the mode and resets the phase.
//  m_axis_tdata    out  N*B    lane k real output at [Bk +: B].
//  m_axis_tvalid   out  1      output beat valid.
//  m_axis_tready   in   1      downstream ready.
//  m_axis_tlast    out  1      tlast delayed with its data.
//  MODE_REG        in   2      0 bypass, 1 fs/2, 2 fs/4 (+), 3 fs/4 (-).
// BEHAVIOUR
//  Reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, phase=0, mode_r=MODE_REG, both stages empty.
//  Pipeline: 2 register stages (S1 capture, S2 mix/output). Global enable en = !m_axis_tvalid | m_axis_tready.
//   s_axis_tready = en. When en=1 all stages advance, including bubbles. When en=0 all stages hold.
//   Latency is 2 cycles from the accept edge to m_axis_tvalid with no stall. Throughput is 1 beat/clk.
//  Phase: 2-bit ph = global sample index mod 4 of lane 0. Lane k uses p=(ph+k) mod 4.
//   ph += N mod 4 on each accepted beat. On an accepted tlast beat, ph=0 for the next beat.
//  Mode: mode_r is used for the mixing. It loads from MODE_REG on an accepted tlast beat, taking effect
//   from the next beat. It also loads on reset. A MODE_REG change mid-packet has no effect until tlast.
//  Mixing, y = real part of (I+jQ)*rot^p:
//   mode0: y=I.
//   mode1: p even -> I; p odd -> -I.
//   mode2: p0 I, p1 -Q, p2 -I, p3 Q.
//   mode3: p0 I, p1 Q, p2 -I, p3 -Q.
//  ph and mode are captured into S1 with the data, so each beat carries its own phase and mode through stalls.
//  Negation: -x is computed at B+1 bits, then reduced to B bits (see CONFIGURATION).
//  tlast passes through with its beat. There is no packet-length requirement; a 1-beat packet is legal.
//  Simultaneous accept and tlast: the beat itself uses the old mode and old ph; the update applies after.
//  rst during a stall or mid-packet: all in-flight beats are dropped and there is no output beat.
// CONFIGURATION
//  MIXER_SAT_EN defined: negation saturates, so -(-2^(B-1)) = 2^(B-1)-1. All other values are exact.
//  MIXER_SAT_EN undefined: negation wraps in two's complement, so -(-2^(B-1)) = -2^(B-1). Saves logic.
// TESTING
//  1 rst; N=16, B=16, mode0; I[k]=k, Q[k]=100+k, 1 beat -> y[k]=k; m_axis_tvalid 2 clk after accept.
//  2 mode2, N=16, I=1000, Q=-500 all lanes -> y per lane: 1000,500,-1000,-500 repeating;
//    mode3 -> 1000,-500,-1000,500.
//  3 N=6, mode1, I=7, 3 beats no tlast -> beat0 +,-,+,-,+,-; beat1 same (ph=2);
//    beat2 same. Then N=6, mode2 -> beat1 lane0 uses p=2 -> y=-7.
//  4 MODE_REG 0->2 mid-packet -> outputs stay bypass until the beat after tlast; then lane0 p=0.
//  5 m_axis_tready random 50% with continuous valid -> no loss or dup; order and per-beat mode/phase match
//    the model; s_axis_tready=0 exactly when m_axis_tvalid=1 and m_axis_tready=0.
//  6 I=-32768, mode1, lane1 -> 32767 with MIXER_SAT_EN; -32768 without.

Source files
------------

// File: rtl/axis_mixer_fs4.sv
// AXI-Stream fs/4 / fs/2 mixer: N complex lanes in, N real lanes out, two-stage pipeline.
// Define MIXER_SAT_EN to make negation of the most negative sample saturate instead of wrap.
module axis_mixer_fs4 #(
    parameter int N = 16,
    parameter int B = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*2*B-1:0]   s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    output logic [N*B-1:0]     m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    input  logic [1:0]         MODE_REG
);

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_FS2    = 2'd1,
        MODE_FS4P   = 2'd2,
        MODE_FS4N   = 2'd3
    } mode_t;

    localparam logic [1:0] PH_STEP = 2'(N % 4);

    logic             en;
    logic [1:0]       ph;
    mode_t            mode_r;
    logic             s1_valid;
    logic             s1_last;
    logic [N*2*B-1:0] s1_data;
    logic [1:0]       s1_ph;
    mode_t            s1_mode;
    logic [N*B-1:0]   mix_data;

    // One enable for every stage: the pipeline moves as a whole, bubbles included.
    assign en            = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = en;

    function automatic logic [B-1:0] negate(input logic [B-1:0] x);
        logic [B:0] n;
        n = -{x[B-1], x};
`ifdef MIXER_SAT_EN
        // Only -(-2^(B-1)) leaves the B-bit range; clamp it to the positive maximum.
        if (n[B] != n[B-1])
            return {1'b0, {(B-1){1'b1}}};
        else
            return n[B-1:0];
`else
        return n[B-1:0];
`endif
    endfunction

    function automatic logic [B-1:0] lane_mix(input mode_t mode, input logic [1:0] p,
                                              input logic [B-1:0] i_s, input logic [B-1:0] q_s);
        logic [B-1:0] y;
        y = i_s;
        case (mode)
            MODE_FS2:  y = p[0] ? negate(i_s) : i_s;
            MODE_FS4P: case (p)
                           2'd0: y = i_s;
                           2'd1: y = negate(q_s);
                           2'd2: y = negate(i_s);
                           default: y = q_s;
                       endcase
            MODE_FS4N: case (p)
                           2'd0: y = i_s;
                           2'd1: y = q_s;
                           2'd2: y = negate(i_s);
                           default: y = negate(q_s);
                       endcase
            default:   y = i_s;
        endcase
        return y;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mix_data = '0;
        for (int k = 0; k < N; k++) begin
            mix_data[B*k +: B] = lane_mix(s1_mode, s1_ph + 2'(k),
                                          s1_data[2*B*k +: B], s1_data[2*B*k+B +: B]);
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: data registers are reset too, since the output bus must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph            <= 2'd0;
            mode_r        <= mode_t'(MODE_REG);
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            s1_data       <= '0;
            s1_ph         <= 2'd0;
            s1_mode       <= MODE_BYPASS;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (en) begin
            s1_valid      <= s_axis_tvalid;
            s1_last       <= s_axis_tvalid && s_axis_tlast;
            s1_data       <= s_axis_tdata;
            s1_ph         <= ph;
            s1_mode       <= mode_r;
            m_axis_tvalid <= s1_valid;
            m_axis_tlast  <= s1_last;
            m_axis_tdata  <= mix_data;
            // The accepted beat carries the old phase/mode; updates apply to the next beat.
            if (s_axis_tvalid) begin
                if (s_axis_tlast) begin
                    ph     <= 2'd0;
                    mode_r <= mode_t'(MODE_REG);
                end else begin
                    ph <= ph + PH_STEP;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_mixer_fs4.sv
// Scoreboard bench for axis_mixer_fs4 (N=6, B=16): a complex-rotation reference model predicts
// each accepted beat; a separate monitor compares every output handshake against the queue.
module tb_axis_mixer_fs4;

    localparam int N  = 6;
    localparam int B  = 16;
    localparam int IW = N * 2 * B;
    localparam int OW = N * B;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [OW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [1:0]    mode_reg;

    beat_t      exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         m_idx    = 0;
    logic [1:0] m_mode   = 2'd0;

    axis_mixer_fs4 #(.N(N), .B(B)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .MODE_REG      (mode_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // y = Re((I + jQ) * rot^p), rot = 1, -1, +j, -j for modes 0..3, then reduced to B bits.
    function automatic logic [B-1:0] ref_mix(input logic [1:0] mode, input int p, input int i_v, input int q_v);
        int re, im, t, cr, ci, y;
        case (mode)
            2'd0: begin cr = 1;  ci = 0;  end
            2'd1: begin cr = -1; ci = 0;  end
            2'd2: begin cr = 0;  ci = 1;  end
            default: begin cr = 0; ci = -1; end
        endcase
        re = i_v;
        im = q_v;
        for (int r = 0; r < p; r++) begin
            t  = re * cr - im * ci;
            im = re * ci + im * cr;
            re = t;
        end
        y = re;
        if (y > (1 << (B-1)) - 1) begin
`ifdef MIXER_SAT_EN
            y = (1 << (B-1)) - 1;
`else
            y = y - (1 << B);
`endif
        end
        return y[B-1:0];
    endfunction

    task automatic model_accept(input logic [IW-1:0] d, input logic l, input logic [1:0] mreg);
        beat_t b;
        logic signed [B-1:0] i_s, q_s;
        for (int k = 0; k < N; k++) begin
            i_s = d[2*B*k +: B];
            q_s = d[2*B*k+B +: B];
            b.data[B*k +: B] = ref_mix(m_mode, (m_idx + k) % 4, int'(i_s), int'(q_s));
        end
        b.last = l;
        exp_q.push_back(b);
        if (l) begin
            m_idx  = 0;
            m_mode = mreg;
        end else begin
            m_idx = m_idx + N;
        end
    endtask

    // One clock of stimulus; also confirms ready is low exactly while the output is stalled.
    task automatic cycle(input logic v, input logic l, input logic [1:0] mreg, input logic rdy,
                         input logic [IW-1:0] d);
        @(negedge clk);
        s_tvalid = v;
        s_tlast  = l;
        mode_reg = mreg;
        m_tready = rdy;
        s_tdata  = d;
        #1;
        check("s_tready", 128'(s_tready), 128'(!(m_tvalid && !m_tready)));
        if (v && s_tready) model_accept(d, l, mreg);
    endtask

    task automatic do_reset(input logic [1:0] mreg);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        mode_reg = mreg;
        rst      = 1'b1;
        #1;
        exp_q.delete();
        m_idx  = 0;
        m_mode = mreg;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_tvalid", 128'(m_tvalid), 128'(0));
        check("rst_tlast",  128'(m_tlast),  128'(0));
        check("rst_tdata",  128'(m_tdata),  128'(0));
    endtask

    function automatic logic [IW-1:0] pack_all(input int i_v, input int q_v);
        logic [IW-1:0] d;
        for (int k = 0; k < N; k++) begin
            d[2*B*k +: B]   = B'(i_v);
            d[2*B*k+B +: B] = B'(q_v);
        end
        return d;
    endfunction

    function automatic logic [B-1:0] rand_sample();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return {1'b1, {(B-1){1'b0}}};
        if (r == 1) return {1'b0, {(B-1){1'b1}}};
        return B'($urandom);
    endfunction

    // Monitor: every output handshake must match the head of the expected queue.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            #2;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 128'(1), 128'(0));
                end else begin
                    b = exp_q.pop_front();
                    check("m_tdata", 128'(m_tdata), 128'(b.data));
                    check("m_tlast", 128'(m_tlast), 128'(b.last));
                end
            end
        end
    end

    initial begin
        logic [IW-1:0] d;
        logic [1:0]    mreg;
        int            guard;

        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0; mode_reg = 2'd0;
        do_reset(2'd0);

        // Bypass beat I=k, Q=100+k; also check the 2-cycle latency.
        for (int k = 0; k < N; k++) begin
            d[2*B*k +: B]   = B'(k);
            d[2*B*k+B +: B] = B'(100 + k);
        end
        cycle(1'b1, 1'b1, 2'd2, 1'b1, d);
        cycle(1'b0, 1'b0, 2'd2, 1'b1, '0);
        check("latency_s1", 128'(m_tvalid), 128'(0));
        cycle(1'b0, 1'b0, 2'd2, 1'b1, '0);
        check("latency_out", 128'(m_tvalid), 128'(1));

        // fs/4 (+) then fs/4 (-) on I=1000, Q=-500, then fs/2 on the most negative I.
        cycle(1'b1, 1'b1, 2'd3, 1'b1, pack_all(1000, -500));
        cycle(1'b1, 1'b1, 2'd1, 1'b1, pack_all(1000, -500));
        cycle(1'b1, 1'b0, 2'd1, 1'b1, pack_all(-32768, 0));
        cycle(1'b1, 1'b0, 2'd2, 1'b1, pack_all(7, 3));
        cycle(1'b1, 1'b1, 2'd2, 1'b1, pack_all(7, 3));
        cycle(1'b1, 1'b0, 2'd0, 1'b1, pack_all(7, 3));
        cycle(1'b1, 1'b0, 2'd0, 1'b1, pack_all(7, 3));

        // Randomised traffic with backpressure, mid-packet mode changes and one reset under stall.
        mreg = 2'd0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2 * N; k++) d[B*k +: B] = rand_sample();
            if ($urandom_range(0, 9) == 0) mreg = 2'($urandom);
            if (c == 1500) do_reset(mreg);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, mreg,
                  1'($urandom_range(0, 1)), d);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            cycle(1'b0, 1'b0, mreg, 1'b1, '0);
            guard++;
        end
        check("drain_empty", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
